// File: rtl/mipi_csi_pkg.sv
// Shared types and defaults for the CSI-2 receive lane aligner.
package mipi_csi_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ALL  = 2'd1,
        ALIGNED   = 2'd2,
        ERR_DRAIN = 2'd3
    } align_state_e;

    typedef enum logic [1:0] {
        LANES_1     = 2'b00,
        LANES_2     = 2'b01,
        LANES_4_ALT = 2'b10,
        LANES_4     = 2'b11
    } lane_cfg_e;

    localparam int DEFAULT_MAX_SKEW = 7;

    // The unused 10 encoding falls back to 4 lanes.
    function automatic int lane_count(input logic [1:0] cfg);
        case (lane_cfg_e'(cfg))
            LANES_1: return 1;
            LANES_2: return 2;
            default: return 4;
        endcase
    endfunction

endpackage

// File: rtl/csi_lane_delay_line.sv
// One lane's {valid,data} shift register with a selectable output tap.
module csi_lane_delay_line #(
    parameter int DEPTH = 8,
    parameter int TAP_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid,
    input  logic [7:0]       data,
    input  logic [TAP_W-1:0] tap,
    output logic             tap_valid,
    output logic [7:0]       tap_data
);

    logic [8:0] stages [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= {valid, data};
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    always_comb begin
        tap_valid = 1'b0;
        tap_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap == TAP_W'(i)) begin
                {tap_valid, tap_data} = stages[i];
            end
        end
    end

endmodule

// File: rtl/csi_lane_aligner.sv
// D-PHY HS lane deskew: measures per-lane start offsets and re-times lanes from delay-line taps.
// Optional statistics outputs are enabled with CSI_LANE_ALIGN_STATS_EN.
module csi_lane_aligner
    import mipi_csi_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int MAX_SKEW  = DEFAULT_MAX_SKEW
) (
    input  logic                   rx_byte_clk_hs_i,
    input  logic                   reset_n_i,
    input  logic [1:0]             active_lanes_i,
    input  logic [NUM_LANES-1:0]   rx_valid_hs_i,
    input  logic [NUM_LANES*8-1:0] rx_data_hs_i,
    output logic                   lane_valid_o,
    output logic [NUM_LANES*8-1:0] lane_data_o,
    output logic                   err_skew_o
`ifdef CSI_LANE_ALIGN_STATS_EN
    ,
    output logic [15:0]            err_count_o,
    output logic [2:0]             last_skew_o
`endif
);

    localparam int DEPTH = MAX_SKEW + 1;
    localparam int TAP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(MAX_SKEW + 2);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_SKEW + 1);

    align_state_e         state;
    logic [CNT_W-1:0]     skew_cnt;
    logic [NUM_LANES-1:0] mask_q;
    logic [NUM_LANES-1:0] started;
    logic [NUM_LANES-1:0] prev_valid;
    logic [TAP_W-1:0]     offset [NUM_LANES];
    logic [TAP_W-1:0]     tap [NUM_LANES];
    logic [NUM_LANES-1:0] tap_valid;
    logic [7:0]           tap_data [NUM_LANES];

    logic [NUM_LANES-1:0] mask_now;
    logic [NUM_LANES-1:0] rise;
    logic [NUM_LANES-1:0] started_nxt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 all_tapped;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        csi_lane_delay_line #(
            .DEPTH (DEPTH),
            .TAP_W (TAP_W)
        ) u_delay (
            .clk       (rx_byte_clk_hs_i),
            .reset_n   (reset_n_i),
            .valid     (rx_valid_hs_i[k]),
            .data      (rx_data_hs_i[k*8 +: 8]),
            .tap       (tap[k]),
            .tap_valid (tap_valid[k]),
            .tap_data  (tap_data[k])
        );
    end

    // A lane "starts" on a valid rising edge; prev_valid resets high so lanes caught mid-packet
    // by a reset must drop valid before they can start again.
    always_comb begin
        mask_now = mask_q;
        if (state == IDLE) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                mask_now[k] = (k < lane_count(active_lanes_i));
            end
        end
        rise        = rx_valid_hs_i & ~prev_valid & mask_now;
        cnt_nxt     = skew_cnt + 1'b1;
        started_nxt = started | rise;
        all_tapped  = &(tap_valid | ~mask_q);
    end

    always_ff @(posedge rx_byte_clk_hs_i) begin
        if (!reset_n_i) begin
            state        <= IDLE;
            skew_cnt     <= '0;
            mask_q       <= '0;
            started      <= '0;
            prev_valid   <= '1;
            lane_valid_o <= 1'b0;
            lane_data_o  <= '0;
            err_skew_o   <= 1'b0;
            for (int k = 0; k < NUM_LANES; k++) begin
                offset[k] <= '0;
                tap[k]    <= '0;
            end
        end else begin
            prev_valid   <= rx_valid_hs_i;
            err_skew_o   <= 1'b0;
            lane_valid_o <= 1'b0;
            lane_data_o  <= '0;
            case (state)
                IDLE: begin
                    mask_q   <= mask_now;
                    skew_cnt <= '0;
                    started  <= rise;
                    for (int k = 0; k < NUM_LANES; k++) begin
                        offset[k] <= '0;
                        tap[k]    <= '0;
                    end
                    if (rise == mask_now) begin
                        state <= ALIGNED;
                    end else if (|rise) begin
                        state <= WAIT_ALL;
                    end
                end
                WAIT_ALL: begin
                    skew_cnt <= cnt_nxt;
                    started  <= started_nxt;
                    for (int k = 0; k < NUM_LANES; k++) begin
                        if (rise[k] && !started[k]) begin
                            offset[k] <= TAP_W'(cnt_nxt);
                        end
                    end
                    if (cnt_nxt == CNT_LIMIT) begin
                        err_skew_o <= 1'b1;
                        state      <= ERR_DRAIN;
                    end else if (started_nxt == mask_q) begin
                        state <= ALIGNED;
                        // Tap = last lane's offset minus own offset; lanes starting now sit at stage 0.
                        for (int k = 0; k < NUM_LANES; k++) begin
                            tap[k] <= (rise[k] && !started[k]) ? '0 : TAP_W'(cnt_nxt) - offset[k];
                        end
                    end
                end
                ALIGNED: begin
                    if (all_tapped) begin
                        lane_valid_o <= 1'b1;
                        for (int k = 0; k < NUM_LANES; k++) begin
                            if (mask_q[k]) begin
                                lane_data_o[k*8 +: 8] <= tap_data[k];
                            end
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                ERR_DRAIN: begin
                    if (rx_valid_hs_i == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CSI_LANE_ALIGN_STATS_EN
    always_ff @(posedge rx_byte_clk_hs_i) begin
        if (!reset_n_i) begin
            err_count_o <= '0;
            last_skew_o <= '0;
        end else begin
            if (err_skew_o && err_count_o != 16'hFFFF) begin
                err_count_o <= err_count_o + 16'd1;
            end
            if (state == IDLE && rise == mask_now) begin
                last_skew_o <= '0;
            end else if (state == WAIT_ALL && cnt_nxt != CNT_LIMIT && started_nxt == mask_q) begin
                last_skew_o <= 3'(cnt_nxt);
            end
        end
    end
`endif

endmodule

// File: doc/csi_lane_aligner.md
CSI_LANE_ALIGNER -- requirements
Module: csi_lane_aligner

Interface
REQ-001 SHALL have parameter NUM_LANES, 4, number of physical D-PHY HS lanes.
REQ-002 SHALL have parameter MAX_SKEW, 7, maximum inter-lane skew in byte-clock cycles; the delay-line depth is MAX_SKEW+1.
REQ-003 SHALL use one clock and a synchronous, active-low reset.
REQ-004 SHALL have port rx_byte_clk_hs_i, input, 1, the HS byte clock and the only clock.
REQ-005 SHALL have port reset_n_i, input, 1, synchronous active-low reset.
REQ-006 SHALL have port active_lanes_i, input, 2, lane config: 00=1 lane, 01=2 lanes, 11=4 lanes; 10 is treated as 4 lanes.
REQ-007 SHALL have port rx_valid_hs_i, input, NUM_LANES, per-lane HS valid from the PHY.
REQ-008 SHALL have port rx_data_hs_i, input, NUM_LANES x 8, per-lane HS byte from the PHY.
REQ-009 SHALL have port lane_valid_o, output, 1, common valid for the aligned lanes.
REQ-010 SHALL have port lane_data_o, output, NUM_LANES x 8, aligned bytes; bytes of inactive lanes are 0.
REQ-011 SHALL have port err_skew_o, output, 1, one-cycle pulse when deskew times out.

Function
REQ-012 SHALL register each lane's {valid,data} into a per-lane shift delay line of MAX_SKEW+1 stages.
REQ-013 SHALL implement the states IDLE, WAIT_ALL, ALIGNED and ERR_DRAIN.
REQ-014 SHALL sample active_lanes_i only in IDLE; a change in any other state is ignored until the next return to IDLE.
REQ-015 SHALL, in IDLE, move to WAIT_ALL when any active lane's valid is high, clear the skew counter, and record start offset 0 for every lane valid in that cycle.
REQ-016 SHALL, in WAIT_ALL, increment the skew counter each cycle and record the counter value as the start offset of each active lane whose first valid arrives.
REQ-017 SHALL, when the last active lane's first valid arrives, set per-lane tap = last offset - own offset and enter ALIGNED; if all active lanes start in the same cycle, IDLE goes directly to ALIGNED with all taps 0.
REQ-018 SHALL, if the skew counter reaches MAX_SKEW+1 before all active lanes start, pulse err_skew_o for one cycle and enter ERR_DRAIN.
REQ-019 SHALL, in ERR_DRAIN, hold lane_valid_o low until all rx_valid_hs_i bits are low, then return to IDLE.
REQ-020 SHALL, in ALIGNED, take each lane's output from its delay-line tap stage through an output register.
REQ-021 SHALL drive lane_valid_o high 2 cycles after the cycle in which the last active lane first presents valid, with lane_data_o[k] equal to lane k's first byte.
REQ-022 SHALL drive lane_valid_o as the AND of the tapped valids of the active lanes.
REQ-023 SHALL return to IDLE on the first cycle that AND is 0, discarding the trailing bytes of lanes whose valid ends later (EoT skew).
REQ-024 SHALL provide no backpressure; one aligned word is produced per cycle.
REQ-025 SHALL behave as a lane pass-through in 1-lane mode: latency 2, err_skew_o never asserted.

Reset
REQ-026 SHALL, when reset_n_i is low at a clock edge, set state to IDLE, clear the delay lines, taps and counter, and drive lane_valid_o=0, lane_data_o=0, err_skew_o=0.
REQ-027 SHALL, on reset mid-packet, drop the packet, with the first word after reset release requiring a fresh start of all lanes.

Configuration
REQ-028 SHALL, with CSI_LANE_ALIGN_STATS_EN defined, add output err_count_o (16 bits, saturating count of err_skew_o pulses, reset to 0) and output last_skew_o (3 bits, the final skew counter value of the last successful alignment, reset to 0).
REQ-029 SHALL, without CSI_LANE_ALIGN_STATS_EN, omit those ports and their logic; alignment behaviour is identical in both cases.

Structure
REQ-030 SHALL place the state enum align_state_e, the lane-config enum lane_cfg_e and the default MAX_SKEW constant in the shared package mipi_csi_pkg.
REQ-031 SHALL implement the per-lane delay line with tap mux as sub-module csi_lane_delay_line, instantiated NUM_LANES times.

Verification
REQ-032 SHALL cover the 4-lane zero-skew case: all lanes go valid together with bytes 0x11,0x22,0x33,0x44 -> lane_valid_o high 2 cycles later with lane_data_o={0x11,0x22,0x33,0x44}; err_skew_o stays 0.
REQ-033 SHALL cover 4-lane skew {0,2,5,3} cycles with each lane's first byte 0xB8 -> lane_valid_o rises 2 cycles after lane 2 starts, all four first bytes are 0xB8, and following words stay aligned.
REQ-034 SHALL cover skew overflow: lane 3 starts 8 cycles after lane 0 (MAX_SKEW=7) -> one err_skew_o pulse, lane_valid_o never rises, return to IDLE after all valids are low; err_count_o = 1 with the macro.
REQ-035 SHALL cover 2-lane mode (active_lanes_i=01) with lanes 2/3 toggling randomly -> lanes 2/3 are ignored, lane_data_o[2..3] = 0, and lanes 0/1 align with 1-cycle skew.
REQ-036 SHALL cover reset_n_i pulsed low for 1 cycle in ALIGNED mid-packet -> next cycle all outputs are 0 and state is IDLE; a new packet aligns correctly.
REQ-037 SHALL cover EoT skew: lane 1 valid ends 3 cycles after lane 0 -> lane_valid_o falls on the first word missing lane 0 and the trailing lane 1 bytes are never output.
